// File: rtl/nv_nvdla_mcif_wr_os_tracker_if.sv
// Request and AXI B handshake bundle between the write ingress arbiter,
// the outstanding-write tracker and the NOC B channel.
interface nv_nvdla_mcif_wr_os_tracker_if #(
   parameter int CIDX_W = 2,
   parameter int ID_W   = 8,
   parameter int LEN_W  = 2
);
   logic              req_vld;
   logic              req_rdy;
   logic [CIDX_W-1:0] req_client;
   logic [LEN_W-1:0]  req_len;
   logic              req_ack;
   logic              noc2mcif_axi_b_bvalid;
   logic              noc2mcif_axi_b_bready;
   logic [ID_W-1:0]   noc2mcif_axi_b_bid;

   modport master (
      output req_vld, req_client, req_len, req_ack,
      output noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
      input  req_rdy, noc2mcif_axi_b_bready
   );

   modport slave (
      input  req_vld, req_client, req_len, req_ack,
      input  noc2mcif_axi_b_bvalid, noc2mcif_axi_b_bid,
      output req_rdy, noc2mcif_axi_b_bready
   );
endinterface

// File: rtl/nv_nvdla_mcif_wr_os_tracker.sv
// Outstanding-write tracker: admits requests against a beat budget, queues
// {ack,len} per client and turns in-order B responses into completion pulses.
module nv_nvdla_mcif_wr_os_tracker_cq #(
   parameter int DEPTH = 16,
   parameter int LEN_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             push_ack,
   input  logic [LEN_W-1:0] push_len,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             head_ack,
   output logic [LEN_W-1:0] head_len
);
   localparam int AW = $clog2(DEPTH);

   logic [LEN_W:0]  mem [DEPTH];
   logic [AW-1:0]   wp, rp;
   logic [AW:0]     cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   // Payload storage needs no reset: it is only read when cnt says it is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {push_ack, push_len};
   end

   assign full                 = (cnt == (AW+1)'(DEPTH));
   assign empty                = (cnt == '0);
   assign {head_ack, head_len} = mem[rp];
endmodule

module nv_nvdla_mcif_wr_os_tracker #(
   parameter int NUM_CLIENTS = 3,
   parameter int CIDX_W      = 2,
   parameter int ID_W        = 8,
   parameter int LEN_W       = 2,
   parameter int OS_W        = 8,
   parameter int CQ_DEPTH    = 16
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rstn,
   input  logic [OS_W-1:0]        reg2dp_wr_os_cnt,
   nv_nvdla_mcif_wr_os_tracker_if.slave bus,
   output logic [NUM_CLIENTS-1:0] wr_rsp_complete,
   output logic [OS_W:0]          os_cnt_cur,
   output logic                   err_unexp_b
);
   logic [CIDX_W-1:0]                  b_cidx;
   logic                               b_hs, b_hit, b_has, accept, q_room, credit_ok, bready_q;
   logic [LEN_W-1:0]                   hd_len;
   logic [NUM_CLIENTS-1:0]             q_full, q_empty, q_hd_ack, push, pop;
   logic [NUM_CLIENTS-1:0][LEN_W-1:0]  q_hd_len;
   logic [OS_W+1:0]                    need, limit;
   logic [OS_W:0]                      inc, dec;
   logic                               unused_bid_hi;

   assign b_cidx        = bus.noc2mcif_axi_b_bid[CIDX_W-1:0];
   assign unused_bid_hi = ^bus.noc2mcif_axi_b_bid[ID_W-1:CIDX_W];

   generate
      for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_cq
         assign push[c] = accept && (bus.req_client == CIDX_W'(c));
         assign pop[c]  = b_hit && (b_cidx == CIDX_W'(c));
         nv_nvdla_mcif_wr_os_tracker_cq #(.DEPTH(CQ_DEPTH), .LEN_W(LEN_W)) u_cq (
            .clk      (nvdla_core_clk),
            .rst_n    (nvdla_core_rstn),
            .push     (push[c]),
            .push_ack (bus.req_ack),
            .push_len (bus.req_len),
            .pop      (pop[c]),
            .full     (q_full[c]),
            .empty    (q_empty[c]),
            .head_ack (q_hd_ack[c]),
            .head_len (q_hd_len[c])
         );
      end
   endgenerate

   // Index muxes by loop so an out-of-range client simply matches nothing.
   always_comb begin
      q_room = 1'b0;
      b_has  = 1'b0;
      hd_len = '0;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
         if (bus.req_client == CIDX_W'(c)) q_room = !q_full[c];
         if (b_cidx == CIDX_W'(c)) begin
            b_has  = !q_empty[c];
            hd_len = q_hd_len[c];
         end
      end
   end

   // One extra bit so the budget compare can never wrap.
   assign need      = (OS_W+2)'(os_cnt_cur) + (OS_W+2)'(bus.req_len) + (OS_W+2)'(1);
   assign limit     = (OS_W+2)'(reg2dp_wr_os_cnt) + (OS_W+2)'(1);
   assign credit_ok = (need <= limit);

   assign bus.req_rdy               = credit_ok && q_room;
   assign bus.noc2mcif_axi_b_bready = bready_q;
   assign accept                    = bus.req_vld && bus.req_rdy;
   assign b_hs                      = bus.noc2mcif_axi_b_bvalid && bready_q;
   assign b_hit                     = b_hs && b_has;

   assign inc = accept ? (OS_W+1)'(bus.req_len) + (OS_W+1)'(1) : '0;
   assign dec = b_hit  ? (OS_W+1)'(hd_len) + (OS_W+1)'(1)      : '0;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         bready_q        <= 1'b0;
         os_cnt_cur      <= '0;
         wr_rsp_complete <= '0;
         err_unexp_b     <= 1'b0;
      end else begin
         bready_q        <= 1'b1;
         os_cnt_cur      <= os_cnt_cur + inc - dec;
         wr_rsp_complete <= pop & q_hd_ack;
         err_unexp_b     <= err_unexp_b | (b_hs && !b_hit);
      end
   end
endmodule

// File: tb/tb_nv_nvdla_mcif_wr_os_tracker.sv
// Directed bench for the outstanding-write tracker: credit, ack routing,
// queue-full, unexpected B and mid-operation reset.
module tb_nv_nvdla_mcif_wr_os_tracker;
   logic       clk;
   logic       rstn;
   logic [7:0] lim;
   logic [2:0] complete;
   logic [8:0] os_cnt;
   logic       err;
   int         checks = 0;
   int         errors = 0;

   nv_nvdla_mcif_wr_os_tracker_if #(.CIDX_W(2), .ID_W(8), .LEN_W(2)) bus ();

   nv_nvdla_mcif_wr_os_tracker #(
      .NUM_CLIENTS(3), .CIDX_W(2), .ID_W(8), .LEN_W(2), .OS_W(8), .CQ_DEPTH(4)
   ) dut (
      .nvdla_core_clk   (clk),
      .nvdla_core_rstn  (rstn),
      .reg2dp_wr_os_cnt (lim),
      .bus              (bus.slave),
      .wr_rsp_complete  (complete),
      .os_cnt_cur       (os_cnt),
      .err_unexp_b      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic v, input logic [1:0] c, input logic [1:0] l, input logic a);
      bus.req_vld    = v;
      bus.req_client = c;
      bus.req_len    = l;
      bus.req_ack    = a;
   endtask

   task automatic bresp(input logic v, input logic [7:0] id);
      bus.noc2mcif_axi_b_bvalid = v;
      bus.noc2mcif_axi_b_bid    = id;
   endtask

   initial begin
      rstn = 1'b0;
      lim  = 8'd7;
      req(1'b0, 2'd0, 2'd0, 1'b0);
      bresp(1'b0, 8'h00);
      #3;
      chk("rst_bready",   32'(bus.noc2mcif_axi_b_bready), 32'h0);
      chk("rst_os",       32'(os_cnt),   32'h0);
      chk("rst_complete", 32'(complete), 32'h0);
      chk("rst_err",      32'(err),      32'h0);

      @(negedge clk) rstn = 1'b1;
      #1 chk("bready_first_cycle", 32'(bus.noc2mcif_axi_b_bready), 32'h0);
      tick();
      chk("bready_up", 32'(bus.noc2mcif_axi_b_bready), 32'h1);
      chk("idle_os",   32'(os_cnt), 32'h0);

      // Credit limit: budget 8 beats, two 4-beat requests fill it.
      req(1'b1, 2'd0, 2'd3, 1'b1);
      #1 chk("idle_rdy_len3", 32'(bus.req_rdy), 32'h1);
      tick();
      tick();
      req(1'b0, 2'd0, 2'd0, 1'b1);
      #1 chk("credit_os_full", 32'(os_cnt), 32'd8);
      chk("credit_rdy_blocked", 32'(bus.req_rdy), 32'h0);
      bresp(1'b1, 8'h00);
      tick();
      bresp(1'b0, 8'h00);
      #1 chk("credit_os_after_b", 32'(os_cnt), 32'd4);
      chk("credit_complete0", 32'(complete), 32'b001);
      chk("credit_rdy_again", 32'(bus.req_rdy), 32'h1);
      tick();
      chk("credit_pulse_1cyc", 32'(complete), 32'b000);
      bresp(1'b1, 8'h00);
      tick();
      bresp(1'b0, 8'h00);
      #1 chk("credit_drained", 32'(os_cnt), 32'd0);
      tick();

      // Ack routing on client 2, bid upper bits ignored.
      lim = 8'd255;
      req(1'b1, 2'd2, 2'd0, 1'b1);
      tick();
      req(1'b1, 2'd2, 2'd1, 1'b0);
      tick();
      req(1'b1, 2'd2, 2'd2, 1'b1);
      tick();
      req(1'b0, 2'd2, 2'd0, 1'b0);
      #1 chk("ack_os_total", 32'(os_cnt), 32'd6);
      bresp(1'b1, 8'h06);
      tick();
      chk("ack_b1_complete", 32'(complete), 32'b100);
      chk("ack_b1_os",       32'(os_cnt),   32'd5);
      tick();
      chk("ack_b2_complete", 32'(complete), 32'b000);
      chk("ack_b2_os",       32'(os_cnt),   32'd3);
      tick();
      bresp(1'b0, 8'h00);
      chk("ack_b3_complete", 32'(complete), 32'b100);
      chk("ack_b3_os",       32'(os_cnt),   32'd0);
      tick();
      chk("ack_tail_idle", 32'(complete), 32'b000);

      req(1'b0, 2'd3, 2'd0, 1'b0);
      #1 chk("oob_client_rdy", 32'(bus.req_rdy), 32'h0);

      // Queue full on client 1 (depth 4), no bypass on a same-cycle pop.
      req(1'b1, 2'd1, 2'd0, 1'b0);
      tick();
      tick();
      tick();
      tick();
      chk("qfull_rdy", 32'(bus.req_rdy), 32'h0);
      bresp(1'b1, 8'h01);
      #1 chk("qfull_rdy_with_pop", 32'(bus.req_rdy), 32'h0);
      tick();
      bresp(1'b0, 8'h00);
      #1 chk("qfull_rdy_next", 32'(bus.req_rdy), 32'h1);
      chk("qfull_os_after_pop", 32'(os_cnt), 32'd3);
      tick();
      req(1'b0, 2'd1, 2'd0, 1'b0);
      #1 chk("qfull_5th_accepted", 32'(os_cnt), 32'd4);
      chk("qfull_rdy_again", 32'(bus.req_rdy), 32'h0);
      bresp(1'b1, 8'h01);
      tick();
      tick();
      tick();
      tick();
      bresp(1'b0, 8'h00);
      chk("qfull_drained", 32'(os_cnt), 32'd0);
      chk("qfull_noack_nopulse", 32'(complete), 32'b000);
      chk("err_still_clear", 32'(err), 32'h0);

      // Unexpected B responses.
      bresp(1'b1, 8'h00);
      tick();
      bresp(1'b0, 8'h00);
      chk("unexp_empty_err", 32'(err), 32'h1);
      chk("unexp_empty_os",  32'(os_cnt), 32'd0);
      bresp(1'b1, 8'h03);
      tick();
      bresp(1'b0, 8'h00);
      chk("unexp_oob_err",      32'(err),      32'h1);
      chk("unexp_oob_complete", 32'(complete), 32'b000);
      // Push into empty queue with same-cycle B: push lands, B is dropped.
      req(1'b1, 2'd0, 2'd1, 1'b1);
      bresp(1'b1, 8'h00);
      tick();
      req(1'b0, 2'd0, 2'd0, 1'b0);
      bresp(1'b0, 8'h00);
      chk("push_vs_b_os",       32'(os_cnt),   32'd2);
      chk("push_vs_b_complete", 32'(complete), 32'b000);
      bresp(1'b1, 8'h00);
      tick();
      bresp(1'b0, 8'h00);
      chk("push_vs_b_later_pop", 32'(os_cnt),   32'd0);
      chk("push_vs_b_pulse",     32'(complete), 32'b001);
      tick();

      // Mid-operation asynchronous reset with five requests outstanding.
      req(1'b1, 2'd0, 2'd0, 1'b1);
      tick();
      tick();
      req(1'b1, 2'd2, 2'd1, 1'b1);
      tick();
      tick();
      tick();
      req(1'b0, 2'd0, 2'd0, 1'b0);
      #1 chk("midrst_os_before", 32'(os_cnt), 32'd8);
      #2 rstn = 1'b0;
      #1;
      chk("midrst_os",     32'(os_cnt), 32'd0);
      chk("midrst_bready", 32'(bus.noc2mcif_axi_b_bready), 32'h0);
      chk("midrst_err",    32'(err), 32'h0);
      bresp(1'b1, 8'h02);
      tick();
      chk("midrst_no_pulse", 32'(complete), 32'b000);
      @(negedge clk) rstn = 1'b1;
      tick();
      tick();
      bresp(1'b0, 8'h00);
      chk("postrst_old_id_err", 32'(err),      32'h1);
      chk("postrst_no_pulse",   32'(complete), 32'b000);
      chk("postrst_os",         32'(os_cnt),   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
